// File: rtl/sr_cmd_gen.sv
// ---------------------------------------------------------------------------
// sr_cmd_gen
//   Command stage for an SR flip-flop. Two raw, bouncy request lines are
//   synchronized and debounced. Each clean rising edge becomes a sticky
//   request. The requests are then issued as fixed-width s / r pulses that
//   never overlap. A shadow copy of the flip-flop state is kept so that a
//   command which would not change q can be dropped.
//
//   Handshake: there is no valid/ready pair. A request is accepted when its
//   sticky pending flag is set, and it is consumed only in IDLE. One request
//   per channel can be held; repeats of the same request merge into it.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   set_btn   in   raw asynchronous set request, active high
//   clr_btn   in   raw asynchronous clear request, active high
//   s         out  set command to flip-flop (registered)
//   r         out  reset command to flip-flop (registered)
//   busy      out  high whenever the FSM is not IDLE
//   conflict  out  one-cycle pulse when simultaneous set+clear are dropped
//   q_model   out  shadow of flip-flop q
//   q_valid   out  shadow is known (a command was issued since reset)
// ---------------------------------------------------------------------------
module sr_cmd_gen #(
  parameter int DEBOUNCE = 4,
  parameter int PULSE_W  = 2,
  parameter int GAP      = 2,
  parameter int SUPPRESS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic clr_btn,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic q_model,
  output logic q_valid
);

  localparam int CW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int MAXW = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int TW   = $clog2(MAXW + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE_S = 2'd1,
    S_DRIVE_R = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  // Channel 0 is set, channel 1 is clear.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [CW-1:0] cnt [2];
  logic [1:0]    rise;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          set_pend;
  logic          clr_pend;
  logic          take_set;
  logic          take_clr;
  logic          suppress_set;
  logic          suppress_clr;

  assign raw  = {clr_btn, set_btn};
  assign rise = deb & ~deb_d;

  // Synchronizer and debounce. The counter restarts whenever the
  // synchronized level moves. This means only an uninterrupted run that
  // differs from the debounced level can flip it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if ((sync1[i] != sync2[i]) || (sync2[i] == deb[i])) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // IDLE consumes every pending flag it sees. When both are set, both are
  // consumed, and they produce a conflict pulse instead of a command.
  always_comb begin
    take_set     = (state == S_IDLE) && set_pend;
    take_clr     = (state == S_IDLE) && clr_pend;
    suppress_set = (SUPPRESS != 0) && q_valid && q_model;
    suppress_clr = (SUPPRESS != 0) && q_valid && !q_model;
  end

  // Pending flags: a new rising edge wins over a consume in the same cycle.
  // This way a request is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_pend <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      set_pend <= (set_pend && !take_set) || rise[0];
      clr_pend <= (clr_pend && !take_clr) || rise[1];
    end
  end

  // Command FSM with registered outputs and the shadow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      q_model  <= 1'b0;
      q_valid  <= 1'b0;
    end else begin
      conflict <= 1'b0;

      // The flip-flop samples s/r on this same edge, so the shadow follows
      // the registered command values.
      if (s) begin
        q_model <= 1'b1;
        q_valid <= 1'b1;
      end else if (r) begin
        q_model <= 1'b0;
        q_valid <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          tcnt <= '0;
          if (set_pend && clr_pend) begin
            conflict <= 1'b1;
          end else if (set_pend) begin
            if (!suppress_set) begin
              state <= S_DRIVE_S;
              s     <= 1'b1;
              busy  <= 1'b1;
            end
          end else if (clr_pend) begin
            if (!suppress_clr) begin
              state <= S_DRIVE_R;
              r     <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        S_DRIVE_S, S_DRIVE_R: begin
          if (tcnt == TW'(PULSE_W - 1)) begin
            state <= S_GAP;
            s     <= 1'b0;
            r     <= 1'b0;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (tcnt == TW'(GAP - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          s     <= 1'b0;
          r     <= 1'b0;
          busy  <= 1'b0;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// ---------------------------------------------------------------------------
// tb_sr_cmd_gen
//   Directed bench for sr_cmd_gen using the default parameters. A second
//   instance with SUPPRESS=0 shares the same inputs. Outputs are compared
//   as the vector {s, r, busy, conflict, q_model, q_valid}. Edge numbers in
//   the comments count from the first clock edge that samples a changed
//   input.
// ---------------------------------------------------------------------------
module tb_sr_cmd_gen;

  logic clk;
  logic rst_n;
  logic set_btn;
  logic clr_btn;

  logic s, r, busy, conflict, q_model, q_valid;
  logic a_s, a_r, a_busy, a_conflict, a_q_model, a_q_valid;

  int n_checks;
  int n_errors;

  sr_cmd_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_btn  (set_btn),
    .clr_btn  (clr_btn),
    .s        (s),
    .r        (r),
    .busy     (busy),
    .conflict (conflict),
    .q_model  (q_model),
    .q_valid  (q_valid)
  );

  sr_cmd_gen #(.SUPPRESS(0)) dut_nosup (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_btn  (set_btn),
    .clr_btn  (clr_btn),
    .s        (a_s),
    .r        (a_r),
    .busy     (a_busy),
    .conflict (a_conflict),
    .q_model  (a_q_model),
    .q_valid  (a_q_valid)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard / checking
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] main_vec();
    return {2'b00, s, r, busy, conflict, q_model, q_valid};
  endfunction

  function automatic logic [7:0] alt_vec();
    return {2'b00, a_s, a_r, a_busy, a_conflict, a_q_model, a_q_valid};
  endfunction

  task automatic expect_main(input string tag, input logic [5:0] exp);
    check(tag, main_vec(), {2'b00, exp});
  endtask

  task automatic expect_alt(input string tag, input logic [5:0] exp);
    check(tag, alt_vec(), {2'b00, exp});
  endtask

  // s and r must never be high together, in either instance.
  always @(negedge clk) begin
    check("s_r_excl", {7'b0, s & r}, 8'd0);
    check("s_r_excl_nosup", {7'b0, a_s & a_r}, 8'd0);
  end

  // Driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    rst_n   = 1'b1;
    tick(2);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    set_btn  = 1'b0;
    clr_btn  = 1'b0;

    // Reset / idle: toggle inputs while reset is held.
    #1;
    tick(1);
    set_btn = 1'b1;
    tick(2);
    clr_btn = 1'b1;
    set_btn = 1'b0;
    tick(2);
    expect_main("reset_held", 6'b000000);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    rst_n   = 1'b1;
    tick(12);
    expect_main("idle_after_release", 6'b000000);

    // Clean set: s high after edges 8 and 9, busy for edges 8..11.
    set_btn = 1'b1;
    tick(7);  expect_main("set_e7",  6'b000000);
    tick(1);  expect_main("set_e8",  6'b101000);
    tick(1);  expect_main("set_e9",  6'b101011);
    tick(1);  expect_main("set_e10", 6'b001011);
    tick(1);  expect_main("set_e11", 6'b001011);
    tick(1);  expect_main("set_e12", 6'b000011);
    // Clean clear follows.
    set_btn = 1'b0;
    clr_btn = 1'b1;
    tick(7);  expect_main("clr_e7",  6'b000011);
    tick(1);  expect_main("clr_e8",  6'b011011);
    tick(1);  expect_main("clr_e9",  6'b011001);
    tick(1);  expect_main("clr_e10", 6'b001001);
    tick(2);  expect_main("clr_e12", 6'b000001);
    clr_btn = 1'b0;
    tick(10);

    // Bounce: 1,0,1,0 at one-cycle spacing, then held. One pulse, timed
    // from the final rise.
    set_btn = 1'b1; tick(1);
    set_btn = 1'b0; tick(1);
    set_btn = 1'b1; tick(1);
    set_btn = 1'b0; tick(1);
    set_btn = 1'b1;
    tick(7);  expect_main("bounce_e7",  6'b000001);
    tick(1);  expect_main("bounce_e8",  6'b101001);
    tick(1);  expect_main("bounce_e9",  6'b101011);
    tick(3);  expect_main("bounce_e12", 6'b000011);
    set_btn = 1'b0;
    tick(10);

    // A three-cycle glitch on clear must not produce an r pulse.
    clr_btn = 1'b1;
    tick(3);
    clr_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      expect_main("glitch", 6'b000011);
    end
    expect_alt("glitch_nosup", 6'b000011);

    // Conflict: both rise together.
    do_reset();
    set_btn = 1'b1;
    clr_btn = 1'b1;
    tick(7);  expect_main("conf_e7", 6'b000000);
    tick(1);  expect_main("conf_e8", 6'b000100);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      expect_main("conf_after", 6'b000000);
    end
    set_btn = 1'b0;
    clr_btn = 1'b0;
    tick(10);

    // Queueing: clear arrives while the set pulse is in progress. It is
    // served from IDLE, so r rises at edge 13.
    do_reset();
    set_btn = 1'b1;
    tick(2);
    clr_btn = 1'b1;
    tick(6);  expect_main("q_e8",  6'b101000);
    tick(1);  expect_main("q_e9",  6'b101011);
    tick(1);  expect_main("q_e10", 6'b001011);
    tick(1);  expect_main("q_e11", 6'b001011);
    tick(1);  expect_main("q_e12", 6'b000011);
    tick(1);  expect_main("q_e13", 6'b011011);
    tick(1);  expect_main("q_e14", 6'b011001);
    tick(1);  expect_main("q_e15", 6'b001001);
    tick(2);  expect_main("q_e17", 6'b000001);
    expect_alt("q_e17_nosup", 6'b000001);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    tick(12);

    // Suppression: set q, then request set again.
    set_btn = 1'b1;
    tick(12);
    expect_main("sup_first", 6'b000011);
    set_btn = 1'b0;
    tick(10);
    set_btn = 1'b1;
    tick(7);  expect_main("sup_e7", 6'b000011); expect_alt("nosup_e7", 6'b000011);
    tick(1);  expect_main("sup_e8", 6'b000011); expect_alt("nosup_e8", 6'b101011);
    tick(1);  expect_main("sup_e9", 6'b000011); expect_alt("nosup_e9", 6'b101011);
    tick(1);  expect_alt("nosup_e10", 6'b001011);
    tick(2);  expect_main("sup_e12", 6'b000011); expect_alt("nosup_e12", 6'b000011);
    set_btn = 1'b0;
    tick(10);

    // Async reset during DRIVE_S with a clear pending.
    do_reset();
    set_btn = 1'b1;
    tick(2);
    clr_btn = 1'b1;
    tick(6);  expect_main("ar_e8", 6'b101000);
    tick(1);  expect_main("ar_e9", 6'b101011);
    #2;
    rst_n = 1'b0;
    #1;
    expect_main("ar_async", 6'b000000);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      expect_main("ar_lost", 6'b000000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
